// File: rtl/kyber_result_streamer.sv
// Captures the mode-relevant Kyber result buses on the rising edge of finish
// and streams them LSW-first as DATA_W-bit valid/ready words with field tags.
module kyber_result_streamer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              finish,
  input  logic [1:0]        mode,
  input  logic [255:0]      m_out,
  input  logic [6399:0]     pk_out,
  input  logic [6143:0]     sk_out,
  input  logic [6143:0]     c_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_tag,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam int M_W       = 256;
  localparam int PK_W      = 6400;
  localparam int SK_W      = 6144;
  localparam int C_W       = 6144;
  localparam int PAY_W     = PK_W + SK_W;
  localparam int M_WORDS   = M_W / DATA_W;
  localparam int PK_WORDS  = PK_W / DATA_W;
  localparam int SK_WORDS  = SK_W / DATA_W;
  localparam int C_WORDS   = C_W / DATA_W;
  localparam int MAX_WORDS = PAY_W / DATA_W;
  // Wide enough to hold MAX_WORDS itself, so the post-last increment never wraps.
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);

  localparam logic [CNT_W-1:0] PK_CNT    = CNT_W'(PK_WORDS);
  localparam logic [CNT_W-1:0] KEYGEN_LI = CNT_W'(PK_WORDS + SK_WORDS - 1);
  localparam logic [CNT_W-1:0] ENC_LI    = CNT_W'(C_WORDS - 1);
  localparam logic [CNT_W-1:0] DEC_LI    = CNT_W'(M_WORDS - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               finish_d;
  logic               fin_edge;
  logic               capture;
  logic               accept;
  logic               at_last;
  logic [PAY_W-1:0]   payload;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   last_idx;
  logic [1:0]         cap_mode;

  assign fin_edge = finish & ~finish_d;
  assign capture  = (state == IDLE) && fin_edge && (mode != 2'd3);
  assign accept   = (state == STREAM) && out_ready;
  assign at_last  = (cnt == last_idx);

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture)            state_next = STREAM;
      STREAM:  if (accept && at_last)  state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      finish_d <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_next;
      finish_d <= finish;
      // An edge while streaming (including the final-handshake cycle) is dropped.
      overrun  <= fin_edge && (state == STREAM);
    end
  end

  // NOTE: the payload is a plain register, not a RAM, so clearing it on reset is cheap and discards any partial capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      payload  <= '0;
      cnt      <= '0;
      last_idx <= '0;
      cap_mode <= 2'd0;
    end else if (capture) begin
      cnt      <= '0;
      cap_mode <= mode;
      case (mode)
        2'd0: begin
          payload  <= {sk_out, pk_out};
          last_idx <= KEYGEN_LI;
        end
        2'd1: begin
          payload  <= PAY_W'(c_out);
          last_idx <= ENC_LI;
        end
        default: begin
          payload  <= PAY_W'(m_out);
          last_idx <= DEC_LI;
        end
      endcase
    end else if (accept) begin
      payload <= payload >> DATA_W;
      cnt     <= cnt + 1'b1;
    end
  end

  assign out_valid = (state == STREAM);
  assign busy      = (state == STREAM);
  assign out_data  = out_valid ? payload[DATA_W-1:0] : '0;
  assign out_last  = out_valid && at_last;

  always_comb begin
    out_tag = 2'd0;
    if (state == STREAM) begin
      case (cap_mode)
        2'd0:    out_tag = (cnt < PK_CNT) ? 2'd1 : 2'd2;
        2'd1:    out_tag = 2'd3;
        default: out_tag = 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_result_streamer.sv
// Scoreboard bench for kyber_result_streamer (DATA_W=32): expected words are
// queued when a capture is triggered and compared as the DUT streams them.
module tb_kyber_result_streamer;

  logic           clk = 1'b0;
  logic           rst;
  logic           finish;
  logic [1:0]     mode;
  logic [255:0]   m_out;
  logic [6399:0]  pk_out;
  logic [6143:0]  sk_out;
  logic [6143:0]  c_out;
  logic [31:0]    out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [1:0]     out_tag;
  logic           out_last;
  logic           busy;
  logic           overrun;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  tag;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  int   n_ovr = 0;
  bit   ready_toggle = 1'b0;

  kyber_result_streamer #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .finish    (finish),
    .mode      (mode),
    .m_out     (m_out),
    .pk_out    (pk_out),
    .sk_out    (sk_out),
    .c_out     (c_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sink: always ready, or toggling every cycle for backpressure.
  always @(posedge clk) begin
    #1;
    out_ready = ready_toggle ? ~out_ready : 1'b1;
  end

  // Monitor samples mid-cycle; a word is consumed when valid & ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) n_ovr++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", out_valid, 1'b0);
        end else begin
          mon_e = exp_q[0];
          check("data", out_data, mon_e.data);
          check("tag",  out_tag,  mon_e.tag);
          check("last", out_last, mon_e.last);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_acc++;
          end
        end
      end
    end
  end

  task automatic push_expected(input logic [1:0] md);
    exp_t e;
    case (md)
      2'd0: begin
        for (int i = 0; i < 200; i++) begin
          e.data = pk_out[i*32 +: 32]; e.tag = 2'd1; e.last = 1'b0;
          exp_q.push_back(e);
        end
        for (int i = 0; i < 192; i++) begin
          e.data = sk_out[i*32 +: 32]; e.tag = 2'd2; e.last = (i == 191);
          exp_q.push_back(e);
        end
      end
      2'd1: begin
        for (int i = 0; i < 192; i++) begin
          e.data = c_out[i*32 +: 32]; e.tag = 2'd3; e.last = (i == 191);
          exp_q.push_back(e);
        end
      end
      2'd2: begin
        for (int i = 0; i < 8; i++) begin
          e.data = m_out[i*32 +: 32]; e.tag = 2'd0; e.last = (i == 7);
          exp_q.push_back(e);
        end
      end
      default: ;
    endcase
  endtask

  task automatic randomize_buses();
    for (int i = 0; i < 8; i++)   m_out[i*32 +: 32]  = $urandom();
    for (int i = 0; i < 200; i++) pk_out[i*32 +: 32] = $urandom();
    for (int i = 0; i < 192; i++) sk_out[i*32 +: 32] = $urandom();
    for (int i = 0; i < 192; i++) c_out[i*32 +: 32]  = $urandom();
  endtask

  task automatic pulse_finish();
    @(posedge clk); #1 finish = 1'b1;
    @(posedge clk); #1 finish = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    #1;
    check({tag, "_busy_low"},  busy,      1'b0);
    check({tag, "_valid_low"}, out_valid, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"},   out_valid, 1'b0);
    check({tag, "_busy"},    busy,      1'b0);
    check({tag, "_data"},    out_data,  32'h0);
    check({tag, "_tag"},     out_tag,   2'd0);
    check({tag, "_last"},    out_last,  1'b0);
    check({tag, "_overrun"}, overrun,   1'b0);
  endtask

  initial begin
    rst    = 1'b1;
    finish = 1'b0;
    mode   = 2'd0;
    m_out  = '0;
    pk_out = '0;
    sk_out = '0;
    c_out  = '0;

    repeat (2) @(posedge clk);
    #1 check_idle_outputs("reset");
    #1 rst = 1'b0;
    @(posedge clk); #1 check_idle_outputs("post_reset");

    // KeyGen: 200 pk words then 192 sk words.
    randomize_buses();
    pk_out[31:0] = 32'hA5A5_0001;
    sk_out[31:0] = 32'h5A5A_0002;
    mode = 2'd0;
    n_acc = 0;
    push_expected(2'd0);
    pulse_finish();
    randomize_buses();
    mode = 2'd1;
    wait_done("keygen", 1000);
    check("keygen_words", n_acc, 392);

    // Dec: 8 words of m_out.
    m_out = 256'hF;
    mode  = 2'd2;
    n_acc = 0;
    push_expected(2'd2);
    pulse_finish();
    m_out = '1;
    wait_done("dec", 100);
    check("dec_words", n_acc, 8);

    // Enc with toggling ready.
    for (int i = 0; i < 192; i++) c_out[i*32 +: 32] = 32'h1000_0000 + i;
    mode = 2'd1;
    n_acc = 0;
    ready_toggle = 1'b1;
    push_expected(2'd1);
    pulse_finish();
    wait_done("enc_bp", 1000);
    check("enc_bp_words", n_acc, 192);
    ready_toggle = 1'b0;

    // Overrun: second finish pulse mid-stream.
    randomize_buses();
    mode  = 2'd1;
    n_acc = 0;
    n_ovr = 0;
    push_expected(2'd1);
    pulse_finish();
    for (int i = 0; i < 500 && n_acc < 10; i++) @(posedge clk);
    check("ovr_reached_word10", n_acc, 10);
    randomize_buses();
    mode = 2'd2;
    pulse_finish();
    wait_done("ovr", 1000);
    check("ovr_words", n_acc, 192);
    check("ovr_pulses", n_ovr, 1);

    // Reset mid-stream, then a fresh Dec stream.
    randomize_buses();
    mode  = 2'd1;
    n_acc = 0;
    push_expected(2'd1);
    pulse_finish();
    for (int i = 0; i < 500 && n_acc < 50; i++) @(posedge clk);
    check("rst_reached_word50", n_acc, 50);
    #2 rst = 1'b1;
    #1 check_idle_outputs("mid_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mode  = 2'd2;
    n_acc = 0;
    push_expected(2'd2);
    pulse_finish();
    wait_done("after_rst", 100);
    check("after_rst_words", n_acc, 8);

    // Reserved mode: nothing happens.
    mode  = 2'd3;
    n_acc = 0;
    n_ovr = 0;
    pulse_finish();
    repeat (20) @(posedge clk);
    #1;
    check("mode3_words",   n_acc, 0);
    check("mode3_overrun", n_ovr, 0);
    check("mode3_busy",    busy,  1'b0);

    // Level finish held 20 cycles: exactly one capture.
    randomize_buses();
    mode  = 2'd2;
    n_acc = 0;
    n_ovr = 0;
    push_expected(2'd2);
    @(posedge clk); #1 finish = 1'b1;
    repeat (20) @(posedge clk);
    #1 finish = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("held_words",   n_acc, 8);
    check("held_drained", exp_q.size(), 0);
    check("held_overrun", n_ovr, 0);
    check("held_busy",    busy,  1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
